// File: rtl/id_hazard_ctrl_pkg.sv
// Shared constants for the decode-stage hazard unit: stall cause codes and the zero register.
package id_hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    HZ_NONE      = 3'd0,
    HZ_LOAD_USE  = 3'd1,
    HZ_MC_RAW    = 3'd2,
    HZ_MC_STRUCT = 3'd3,
    HZ_MC_WAW    = 3'd4
  } hz_cause_e;

  localparam int unsigned ZERO_REG = 0;

  function automatic logic is_mc_cause(input hz_cause_e c);
    return (c == HZ_MC_RAW) || (c == HZ_MC_STRUCT) || (c == HZ_MC_WAW);
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_fwd_sel.sv
// Priority forwarding mux for one operand; the youngest matching stage wins and
// reports whether its result is still pending.
module id_hazard_ctrl_fwd_sel
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FWD_STAGES = 2
) (
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [DATA_W-1:0]            rf_data_i,
  input  logic [FWD_STAGES-1:0]        stg_reg_we_i,
  input  logic [FWD_STAGES*ADDR_W-1:0] stg_dest_i,
  input  logic [FWD_STAGES*DATA_W-1:0] stg_data_i,
  input  logic [FWD_STAGES-1:0]        stg_data_rdy_i,
  output logic [DATA_W-1:0]            data_c,
  output logic                         pending_c
);

  // Scan oldest to youngest so the lowest matching index overrides.
  always_comb begin
    data_c    = rf_data_i;
    pending_c = 1'b0;
    if (addr_i != ADDR_W'(ZERO_REG)) begin
      for (int i = int'(FWD_STAGES) - 1; i >= 0; i--) begin
        if (stg_reg_we_i[i] && (stg_dest_i[i*ADDR_W +: ADDR_W] == addr_i)) begin
          data_c    = stg_data_i[i*DATA_W +: DATA_W];
          pending_c = ~stg_data_rdy_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage forwarding and interlock unit with a single multicycle-op scoreboard.
// Optional stall statistics counters are built when HAZARD_STATS_EN is defined.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned MC_LAT     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [ADDR_W-1:0]            id_rs_addr,
  input  logic [ADDR_W-1:0]            id_rt_addr,
  input  logic                         id_rs_used,
  input  logic                         id_rt_used,
  input  logic [DATA_W-1:0]            id_rs_data_in,
  input  logic [DATA_W-1:0]            id_rt_data_in,
  input  logic                         id_is_mc,
  input  logic                         id_reg_we,
  input  logic [ADDR_W-1:0]            id_dest_addr,
  input  logic [FWD_STAGES-1:0]        stg_reg_we,
  input  logic [FWD_STAGES*ADDR_W-1:0] stg_dest,
  input  logic [FWD_STAGES*DATA_W-1:0] stg_data,
  input  logic [FWD_STAGES-1:0]        stg_data_rdy,
  output logic [DATA_W-1:0]            rs_data,
  output logic [DATA_W-1:0]            rt_data,
  output logic                         stall,
  output logic [2:0]                   stall_cause,
  output logic                         id_advance,
  output logic                         mc_busy,
  output logic [ADDR_W-1:0]            mc_dest,
  output logic                         mc_done
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                  stat_lu_cnt,
  output logic [31:0]                  stat_mc_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(MC_LAT);

  logic [CNT_W-1:0]  mc_cnt_q, mc_cnt_d;
  logic [ADDR_W-1:0] mc_dest_q, mc_dest_d;
  logic              mc_done_q, mc_done_d;
  logic              rs_pend_c, rt_pend_c;
  logic              lu_hz_c, raw_hz_c, struct_hz_c, waw_hz_c;
  logic              mc_busy_c, issue_c;
  hz_cause_e         cause_c;

  id_hazard_ctrl_fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWD_STAGES(FWD_STAGES)) u_fwd_rs (
    .addr_i         (id_rs_addr),
    .rf_data_i      (id_rs_data_in),
    .stg_reg_we_i   (stg_reg_we),
    .stg_dest_i     (stg_dest),
    .stg_data_i     (stg_data),
    .stg_data_rdy_i (stg_data_rdy),
    .data_c         (rs_data),
    .pending_c      (rs_pend_c)
  );

  id_hazard_ctrl_fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWD_STAGES(FWD_STAGES)) u_fwd_rt (
    .addr_i         (id_rt_addr),
    .rf_data_i      (id_rt_data_in),
    .stg_reg_we_i   (stg_reg_we),
    .stg_dest_i     (stg_dest),
    .stg_data_i     (stg_data),
    .stg_data_rdy_i (stg_data_rdy),
    .data_c         (rt_data),
    .pending_c      (rt_pend_c)
  );

  assign mc_busy_c = (mc_cnt_q != '0);

  // Hazard detection and priority encoding of the stall cause.
  always_comb begin
    lu_hz_c     = (id_rs_used & rs_pend_c) | (id_rt_used & rt_pend_c);
    raw_hz_c    = mc_busy_c && (mc_dest_q != ADDR_W'(ZERO_REG)) &&
                  ((id_rs_used && (id_rs_addr == mc_dest_q)) ||
                   (id_rt_used && (id_rt_addr == mc_dest_q)));
    struct_hz_c = id_is_mc && (mc_cnt_q > CNT_W'(1));
    waw_hz_c    = id_reg_we && mc_busy_c && (mc_dest_q != ADDR_W'(ZERO_REG)) &&
                  (id_dest_addr == mc_dest_q);
    cause_c     = HZ_NONE;
    if (id_valid) begin
      if (lu_hz_c)          cause_c = HZ_LOAD_USE;
      else if (raw_hz_c)    cause_c = HZ_MC_RAW;
      else if (struct_hz_c) cause_c = HZ_MC_STRUCT;
      else if (waw_hz_c)    cause_c = HZ_MC_WAW;
    end
  end

  assign stall       = (cause_c != HZ_NONE);
  assign stall_cause = cause_c;
  assign id_advance  = id_valid & ~stall;
  assign issue_c     = id_advance & id_is_mc;

  // Scoreboard next state; an issue at count 1 reloads yet still signals completion.
  always_comb begin
    mc_cnt_d  = mc_cnt_q;
    mc_dest_d = mc_dest_q;
    mc_done_d = 1'b0;
    if (mc_cnt_q == CNT_W'(1)) begin
      mc_done_d = 1'b1;
      mc_dest_d = '0;
    end
    if (mc_busy_c) mc_cnt_d = mc_cnt_q - CNT_W'(1);
    if (issue_c) begin
      mc_cnt_d  = CNT_W'(MC_LAT - 1);
      mc_dest_d = id_reg_we ? id_dest_addr : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_cnt_q  <= '0;
      mc_dest_q <= '0;
      mc_done_q <= 1'b0;
    end else begin
      mc_cnt_q  <= mc_cnt_d;
      mc_dest_q <= mc_dest_d;
      mc_done_q <= mc_done_d;
    end
  end

  assign mc_busy = mc_busy_c;
  assign mc_dest = mc_dest_q;
  assign mc_done = mc_done_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stat_lu_q, stat_mc_q;

  // Saturating stall-cycle counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lu_q <= '0;
      stat_mc_q <= '0;
    end else begin
      if ((cause_c == HZ_LOAD_USE) && (stat_lu_q != '1)) stat_lu_q <= stat_lu_q + 32'd1;
      if (is_mc_cause(cause_c) && (stat_mc_q != '1))     stat_mc_q <= stat_mc_q + 32'd1;
    end
  end

  assign stat_lu_cnt = stat_lu_q;
  assign stat_mc_cnt = stat_mc_q;
`endif

endmodule
